// File: rtl/fifo_stream_reader_pkg.sv
// Shared constants for the FIFO stream reader and its 2-entry output buffer.
`ifndef FIFO_STREAM_READER_PKG_SV
`define FIFO_STREAM_READER_PKG_SV
package fifo_stream_reader_pkg;

  localparam int unsigned FIFO_STREAM_BUF_DEPTH = 2;
  localparam int unsigned FIFO_STREAM_PTR_W     = 1;
  localparam int unsigned FIFO_STREAM_DATA_W    = 32;

  typedef logic [FIFO_STREAM_PTR_W-1:0] buf_ptr_t;

endpackage
`endif

// File: rtl/fifo_stream_skid.sv
// 2-entry circular output buffer with push/pop and occupancy count.
module fifo_stream_skid
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_STREAM_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [FIFO_STREAM_BUF_DEPTH];
  buf_ptr_t              head;
  buf_ptr_t              tail;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem   <= '{default: '0};
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign data  = mem[head];
  assign valid = (count != 2'd0);

`ifndef SYNTHESIS
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && count == 2'd2));
`endif

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a registered-read FIFO into a valid/ready stream via a 2-entry buffer.
// Optional packet framing (m_last, pkt_len) enabled by FIFO_STREAM_LAST_EN.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FIFO_STREAM_DATA_W,
  parameter int unsigned BUF_DEPTH  = FIFO_STREAM_BUF_DEPTH,
  parameter int unsigned PKT_LEN_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_enable,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
`ifdef FIFO_STREAM_LAST_EN
  input  logic [PKT_LEN_W-1:0]  pkt_len,
  output logic                  m_last,
`endif
  output logic [1:0]            buf_count
);

  logic       inflight;
  logic       accept;
  logic [2:0] credit;

  assign accept = m_valid & m_ready;

  // Occupancy as it will stand after this edge, counting the beat still in the FIFO's output register.
  assign credit     = 3'(buf_count) + 3'(inflight) - 3'(accept);
  assign fifo_rd_en = ~rst & rd_enable & ~fifo_empty & (credit < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
    end
  end

  fifo_stream_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (inflight),
    .push_data(fifo_rd_data),
    .pop      (accept),
    .data     (m_data),
    .valid    (m_valid),
    .count    (buf_count)
  );

`ifdef FIFO_STREAM_LAST_EN
  logic [PKT_LEN_W-1:0] beat_cnt;
  logic [PKT_LEN_W-1:0] len_q;
  logic [PKT_LEN_W-1:0] cur_len;

  // Length is taken live on the first beat and held for the rest of the packet.
  assign cur_len = (beat_cnt == '0) ? pkt_len : len_q;
  assign m_last  = m_valid & (beat_cnt == cur_len);

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      len_q    <= '0;
    end else if (accept) begin
      if (beat_cnt == '0) begin
        len_q <= pkt_len;
      end
      beat_cnt <= m_last ? '0 : beat_cnt + 1'b1;
    end
  end
`else
  logic [PKT_LEN_W-1:0] unused_pkt_len;
  assign unused_pkt_len = '0;
`endif

endmodule
